// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates EX/WB redirects, load-use stalls and halt
// into PC/IF-ID enables, mux selects and pipeline flushes, with perf counters.
module fetch_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_req,
  input  logic             branch_ex,
  input  logic             jumpreg_ex,
  input  logic             jump_wb,
  input  logic             halt_id,
  output logic             branchSel,
  output logic             Jump,
  output logic             JumpReg,
  output logic             PCWrite,
  output logic             ifid_write,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_err
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;

  localparam int unsigned RUN_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [RUN_W:0] RUN_MAX = (RUN_W + 1)'(STALL_MAX);

  state_t state, next;
  logic redirect, stall_path;
  logic [RUN_W-1:0] stall_run;
  logic [RUN_W:0]   run_inc;

  assign redirect = (state != BOOT) && (jump_wb || jumpreg_ex || branch_ex);
  assign run_inc  = {1'b0, stall_run} + 1'b1;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      BOOT: next = RUN;
      HALT: next = redirect ? RUN : HALT;
      default: begin
        if (redirect)       next = RUN;
        else if (stall_req) next = STALL;
        else if (halt_id)   next = HALT;
        else                next = RUN;
      end
    endcase
  end

  // Oldest instruction wins: WB jump, then EX jr, then EX branch.
  always_comb begin
    branchSel   = 1'b0;
    Jump        = 1'b0;
    JumpReg     = 1'b0;
    PCWrite     = 1'b0;
    ifid_write  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    stall_path  = 1'b0;
    if (state == BOOT) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (jump_wb) begin
      Jump        = 1'b1;
      PCWrite     = 1'b1;
      ifid_write  = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (jumpreg_ex || branch_ex) begin
      JumpReg     = jumpreg_ex;
      branchSel   = !jumpreg_ex;
      PCWrite     = 1'b1;
      ifid_write  = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end else if (state != HALT && stall_req) begin
      flush_idex  = 1'b1;
      stall_path  = 1'b1;
    end else if (state == HALT || halt_id) begin
      flush_idex  = 1'b1;
    end else begin
      PCWrite     = 1'b1;
      ifid_write  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
      stall_run    <= '0;
      stall_err    <= 1'b0;
    end else begin
      if (redirect && redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + 1'b1;
      if (stall_path && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (stall_path) begin
        if (run_inc >= RUN_MAX) begin
          stall_run <= RUN_MAX[RUN_W-1:0];
          stall_err <= 1'b1;
        end else begin
          stall_run <= run_inc[RUN_W-1:0];
        end
      end else begin
        stall_run <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: a default-width instance plus a
// 4-bit-counter instance share stimulus and are checked against a cycle model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_req = 1'b0, branch_ex = 1'b0, jumpreg_ex = 1'b0, jump_wb = 1'b0, halt_id = 1'b0;

  logic bsel, jmp, jr, pcw, ifw, fif, fid, fex, hlt, err;
  logic [15:0] rcnt, scnt;
  logic bsel4, jmp4, jr4, pcw4, ifw4, fif4, fid4, fex4, hlt4, err4;
  logic [3:0] rcnt4, scnt4;

  always #5 clk = ~clk;

  fetch_ctrl #(.CNT_W(16), .STALL_MAX(8)) u_dut (
    .clk(clk), .reset(rst), .stall_req(stall_req), .branch_ex(branch_ex),
    .jumpreg_ex(jumpreg_ex), .jump_wb(jump_wb), .halt_id(halt_id),
    .branchSel(bsel), .Jump(jmp), .JumpReg(jr), .PCWrite(pcw), .ifid_write(ifw),
    .flush_ifid(fif), .flush_idex(fid), .flush_exmem(fex), .halted(hlt),
    .redirect_cnt(rcnt), .stall_cnt(scnt), .stall_err(err));

  fetch_ctrl #(.CNT_W(4), .STALL_MAX(8)) u_sat (
    .clk(clk), .reset(rst), .stall_req(stall_req), .branch_ex(branch_ex),
    .jumpreg_ex(jumpreg_ex), .jump_wb(jump_wb), .halt_id(halt_id),
    .branchSel(bsel4), .Jump(jmp4), .JumpReg(jr4), .PCWrite(pcw4), .ifid_write(ifw4),
    .flush_ifid(fif4), .flush_idex(fid4), .flush_exmem(fex4), .halted(hlt4),
    .redirect_cnt(rcnt4), .stall_cnt(scnt4), .stall_err(err4));

  typedef struct packed {
    logic bsel, jmp, jr, pcw, ifw, fif, fid, fex, hlt, err, err4;
    logic [31:0] rcnt, scnt, rcnt4, scnt4;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: behavioural flags and unbounded counts.
  bit m_boot = 1'b1, m_halt = 1'b0, m_err = 1'b0;
  int m_rcnt = 0, m_scnt = 0, m_run = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit b, input bit j_r, input bit j, input bit h);
    exp_t e;
    @(posedge clk); #1;
    rst = r; stall_req = s; branch_ex = b; jumpreg_ex = j_r; jump_wb = j; halt_id = h;
    e = '0;
    if (r) begin
      m_boot = 1'b1; m_halt = 1'b0; m_err = 1'b0; m_rcnt = 0; m_scnt = 0; m_run = 0;
    end
    e.hlt = m_halt; e.err = m_err; e.err4 = m_err;
    e.rcnt = sat(m_rcnt, 65535); e.scnt = sat(m_scnt, 65535);
    e.rcnt4 = sat(m_rcnt, 15);   e.scnt4 = sat(m_scnt, 15);
    if (m_boot) begin
      e.fif = 1; e.fid = 1; e.fex = 1;
      if (!r) m_boot = 1'b0;
    end else if (j || j_r || b) begin
      e.jmp = j; e.jr = !j && j_r; e.bsel = !j && !j_r;
      e.pcw = 1; e.ifw = 1; e.fif = 1; e.fid = 1; e.fex = j;
      m_rcnt++; m_run = 0; m_halt = 1'b0;
    end else if (!m_halt && s) begin
      e.fid = 1;
      m_scnt++; m_run++;
      if (m_run >= 8) m_err = 1'b1;
    end else if (m_halt || h) begin
      e.fid = 1; m_halt = 1'b1; m_run = 0;
    end else begin
      e.pcw = 1; e.ifw = 1; m_run = 0;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("branchSel", bsel, e.bsel);
        chk("Jump", jmp, e.jmp);
        chk("JumpReg", jr, e.jr);
        chk("PCWrite", pcw, e.pcw);
        chk("ifid_write", ifw, e.ifw);
        chk("flush_ifid", fif, e.fif);
        chk("flush_idex", fid, e.fid);
        chk("flush_exmem", fex, e.fex);
        chk("halted", hlt, e.hlt);
        chk("stall_err", err, e.err);
        chk("redirect_cnt", int'(rcnt), e.rcnt);
        chk("stall_cnt", int'(scnt), e.scnt);
        chk("redirect_cnt4", int'(rcnt4), e.rcnt4);
        chk("stall_cnt4", int'(scnt4), e.scnt4);
        chk("stall_err4", err4, e.err4);
        chk("PCWrite4", pcw4, e.pcw);
      end
    end
  end

  initial begin
    bit s_prev;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (10) cyc(0, ($urandom % 2) == 0, 0, 0, 0, ($urandom % 2) == 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      bit [2:0] rd;
      rd = 3'($urandom_range(1, 7));
      cyc(0, $urandom % 2 == 0, rd[0], rd[1], rd[2], $urandom % 2 == 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    s_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit s;
      s = s_prev ? ($urandom % 10 != 0) : ($urandom % 4 == 0);
      s_prev = s;
      cyc($urandom % 300 == 0, s, $urandom % 9 == 0, $urandom % 12 == 0,
          $urandom % 12 == 0, $urandom % 25 == 0);
    end
    @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the 5-stage MIPS pipeline. It drives the IF-stage PC-select and PC-write controls (`branchSel`, `Jump`, `JumpReg`, `PCWrite`) and the IF/ID write enable. It also drives the pipeline-register flushes. Redirect requests from EX and WB, load-use stalls and halt decode are arbitrated by a small FSM that also keeps saturating performance counters.

## Interface

Parameters:
- CNT_W, 16, width of the performance counters.
- STALL_MAX, 8, number of consecutive stall cycles that sets `stall_err`.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high.
- stall_req, input, 1, load-use stall request from the hazard unit (ID instruction).
- branch_ex, input, 1, branch in EX resolved taken (`branchTrue` target valid).
- jumpreg_ex, input, 1, `jr` in EX (`readData1_ex` target valid).
- jump_wb, input, 1, `j`/`jal` in WB (`jumpAddr_wb` target valid).
- halt_id, input, 1, halt opcode decoded in ID.
- branchSel, output, 1, IF branch mux select.
- Jump, output, 1, IF jump mux select.
- JumpReg, output, 1, IF jump-register mux select.
- PCWrite, output, 1, PC register load enable.
- ifid_write, output, 1, IF/ID register load enable.
- flush_ifid, output, 1, IF/ID register clear.
- flush_idex, output, 1, ID/EX register clear.
- flush_exmem, output, 1, EX/MEM register clear.
- halted, output, 1, FSM in HALT.
- redirect_cnt, output, CNT_W, count of taken redirects.
- stall_cnt, output, CNT_W, count of stall cycles.
- stall_err, output, 1, sticky: stall run reached STALL_MAX.

## Operation

- States: BOOT, RUN, STALL, HALT. Reset enters BOOT.
- Event priority in every state except BOOT: redirect > stall > halt. Within a redirect: jump_wb > jumpreg_ex > branch_ex. The oldest instruction wins.
- Only one of `Jump`, `JumpReg`, `branchSel` may be high in any cycle: the winning redirect. The other two are 0.
- **jump_wb redirect:**
  - `Jump=1`, `PCWrite=1`, `ifid_write=1`.
  - `flush_ifid=flush_idex=flush_exmem=1`.
- **EX redirect (jumpreg_ex or branch_ex):**
  - `JumpReg` or `branchSel`=1, `PCWrite=1`, `ifid_write=1`.
  - `flush_ifid=flush_idex=1`, `flush_exmem=0`.
- **Stall, no redirect:**
  - `PCWrite=0`, `ifid_write=0`, `flush_idex=1` (bubble).
  - Next state STALL.
- **Halt, no redirect and no stall:**
  - `PCWrite=0`, `ifid_write=0`, `flush_idex=1`.
  - Next state HALT.
- **No event:** `PCWrite=1`, `ifid_write=1`, all flushes 0. Next state RUN.
- **BOOT:**
  - `PCWrite=0`, `ifid_write=0`, all three flushes =1.
  - All inputs are ignored.
  - Next state RUN unconditionally.
- **STALL:** same decode as RUN. Next state is STALL while `stall_req` stays high with no redirect, else RUN (or HALT per the rules above).
- **HALT:**
  - Defaults: `PCWrite=0`, `ifid_write=0`, `flush_idex=1`.
  - `stall_req` and `halt_id` are ignored.
  - A redirect in HALT is older than the halt: it performs the normal redirect outputs and returns to RUN.
  - Otherwise HALT holds until reset.
- **Counters** (saturate at 2^CNT_W−1; no wrap):
  - `redirect_cnt` +1 per cycle with a redirect.
  - `stall_cnt` +1 per cycle the stall path is taken.
- **Stall-run counter (internal):**
  - Increments on each stall cycle and clears on any non-stall cycle.
  - When it reaches STALL_MAX, `stall_err` sets. It stays set until reset.

## Timing

- All select, enable and flush outputs are combinational from the current state and inputs within the cycle.
- The PC loads the selected target at the next rising edge, so redirect latency is 1 cycle.
- Counters, `stall_err` and the state register update on the rising edge. `halted` is registered (decoded from state).
- Reset values (asynchronous, immediate): state BOOT, `redirect_cnt=0`, `stall_cnt=0`, `stall_err=0`, `halted=0`.
- Output values during reset, from BOOT decode: `PCWrite=0`, `ifid_write=0`, flushes=1, selects=0.
- Reset asserted mid-operation discards any pending stall, halt or redirect. The first post-reset cycle is always BOOT.
- The first PC advance occurs at the second rising edge after reset deassertion.
- Simultaneous `jump_wb` and `branch_ex`: only `Jump=1`. `redirect_cnt` +1 (not +2).
- Redirect during a stall: the stall is dropped that cycle, `stall_cnt` does not increment, and the stall run clears.

## Test plan

- Reset, then idle 3 cycles: cycle 0 BOOT with `PCWrite=0` and flushes=1; cycles 1–2 `PCWrite=1`, flushes=0; all counters 0.
- `branch_ex=1` for 1 cycle in RUN: `branchSel=1`, `flush_ifid=flush_idex=1`, `flush_exmem=0`; next cycle `redirect_cnt=1`.
- `jump_wb=1` and `jumpreg_ex=1` and `stall_req=1` together: `Jump=1`, `JumpReg=0`, `PCWrite=1`, three flushes=1; `stall_cnt` unchanged; `redirect_cnt` +1.
- `stall_req` held 8 cycles (STALL_MAX=8): `PCWrite=0` throughout; `stall_cnt=8`; `stall_err=1` after the 8th edge; it stays 1 after `stall_req` drops.
- Halt sequence:
  - `halt_id=1`: `halted=1` next cycle and `PCWrite` stays 0 for 10 cycles.
  - Then `branch_ex=1`: `branchSel=1`, `PCWrite=1`, `halted=0` next cycle.
- Counter saturation: CNT_W=4 with 20 redirect cycles gives `redirect_cnt=15` (held, no wrap). Reset mid-stream clears all counters and `stall_err`.
